// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART definitions. LCR field positions, word-length and
//           parity-mode encodings, receiver state type and small helpers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Line Control Register field positions
  localparam int c_lcr_wls_lsb = 0;  // word length select [1:0]
  localparam int c_lcr_wls_msb = 1;
  localparam int c_lcr_stb     = 2;  // 1.5/2 stop bits (transmit side only)
  localparam int c_lcr_pen     = 3;  // parity enable
  localparam int c_lcr_eps     = 4;  // even parity select
  localparam int c_lcr_sp      = 5;  // stick parity

  typedef enum logic [1:0] {
    WLS_5 = 2'd0,
    WLS_6 = 2'd1,
    WLS_7 = 2'd2,
    WLS_8 = 2'd3
  } wls_t;

  // Encoded as {SP, EPS}
  typedef enum logic [1:0] {
    PAR_ODD    = 2'b00,
    PAR_EVEN   = 2'b01,
    PAR_STICK1 = 2'b10,
    PAR_STICK0 = 2'b11
  } par_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Number of data bits (5..8) for a word-length code
  function automatic logic [3:0] wls_to_bits(input wls_t wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  // High when received data d and parity bit p disagree with the mode.
  // d must already be zero above the word length.
  function automatic logic parity_error(input par_mode_t mode,
                                        input logic [7:0] d,
                                        input logic       p);
    logic w_err;
    case (mode)
      PAR_ODD:    w_err = ~(^d ^ p);
      PAR_EVEN:   w_err = (^d ^ p);
      PAR_STICK1: w_err = ~p;
      default:    w_err = p;
    endcase
    return w_err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync
// Purpose : Metastability synchronizer for an asynchronous level input.
//           Flops reset to 1 so an idle-high line never looks active after
//           reset.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           d     - asynchronous input
//           q     - synchronized output
// Rev     : 1.0  initial release
// ============================================================================
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (SYNC_STAGES <= 1) begin : g_single
      logic r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b1;
        else        r_q <= d;
      end
      assign q = r_q;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] r_chain;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= '1;
        else        r_chain <= {r_chain[SYNC_STAGES-2:0], d};
      end
      assign q = r_chain[SYNC_STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_framer
// Purpose : 16550A-compatible receive deframer. Oversamples rxd, reassembles
//           5-8 data bits LSB-first, checks parity and the first stop bit,
//           and detects break.
// Ports   : clk         - system clock
//           rst_n       - asynchronous active-low reset
//           baud_tick   - one-clk enable, OVERSAMPLE per bit time
//           lcr[7:0]    - Line Control Register (bits [5:0] used)
//           rxd         - serial input, idle high
//           rx_valid    - one-clk pulse when a frame completes
//           rx_data     - received character, zero above word length
//           parity_err  - parity check result, valid with rx_valid
//           framing_err - stop bit sampled 0, valid with rx_valid
//           break_det   - data/parity/stop all 0, valid with rx_valid
//           busy        - receiver not in IDLE
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] lcr,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_det,
  output logic       busy
);

  localparam int TW = (OVERSAMPLE <= 2) ? 1 : $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] c_half_m1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_full_m1 = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] c_tick_one = TW'(1);

  logic            rxs;
  rx_state_t       r_state;
  logic [TW-1:0]   r_tick_cnt;
  logic [2:0]      r_bit_cnt;
  logic [5:0]      r_shadow;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_need_high;
  logic            r_valid;
  logic [7:0]      r_data;
  logic            r_perr;
  logic            r_ferr;
  logic            r_brk;
  logic            r_busy;

  logic [3:0]      w_nbits;
  logic [3:0]      w_nbits_m1;
  logic [7:0]      w_mask;
  logic            w_pen;
  par_mode_t       w_mode;
  logic            w_sample;
  logic            w_last_bit;
  logic            w_perr;
  logic            w_brk;
  logic            w_unused;

  uart_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  // Frame format comes from the shadow copy taken at the start edge
  assign w_nbits    = wls_to_bits(wls_t'(r_shadow[c_lcr_wls_msb:c_lcr_wls_lsb]));
  assign w_nbits_m1 = w_nbits - 4'd1;
  assign w_mask     = 8'hFF >> (4'd8 - w_nbits);
  assign w_pen      = r_shadow[c_lcr_pen];
  assign w_mode     = par_mode_t'({r_shadow[c_lcr_sp], r_shadow[c_lcr_eps]});

  // Mid-bit point for every bit after the start bit: the counter is cleared
  // at the start-bit midpoint, so a full bit time later is mid-bit again.
  assign w_sample   = (r_tick_cnt == c_full_m1);
  assign w_last_bit = ({1'b0, r_bit_cnt} == w_nbits_m1);

  // r_shift is cleared at frame start, so unreceived upper bits are 0
  assign w_perr = w_pen ? parity_error(w_mode, r_shift, r_par) : 1'b0;
  assign w_brk  = (r_shift == 8'h00) && (!w_pen || !r_par) && !rxs;

  // Stop-bit count and LCR[7:6] have no effect on reception
  assign w_unused = ^{lcr[7:6], r_shadow[c_lcr_stb]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= 3'd0;
      r_shadow    <= 6'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_need_high <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= 8'h00;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_brk       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (baud_tick) begin
        case (r_state)
          IDLE: begin
            if (r_need_high) begin
              // After a break/framing error the line must return high
              // before another start bit is accepted.
              if (rxs) r_need_high <= 1'b0;
            end else if (!rxs) begin
              r_state    <= START;
              r_busy     <= 1'b1;
              r_tick_cnt <= '0;
              r_shadow   <= lcr[5:0];
            end
          end

          START: begin
            if (r_tick_cnt == c_half_m1) begin
              r_tick_cnt <= '0;
              if (rxs) begin
                // Line went back high before mid-bit: glitch, not a start
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= DATA;
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + c_tick_one;
            end
          end

          DATA: begin
            r_tick_cnt <= w_sample ? '0 : r_tick_cnt + c_tick_one;
            if (w_sample) begin
              r_shift[r_bit_cnt] <= rxs;
              r_bit_cnt          <= r_bit_cnt + 3'd1;
              if (w_last_bit) r_state <= w_pen ? PARITY : STOP;
            end
          end

          PARITY: begin
            r_tick_cnt <= w_sample ? '0 : r_tick_cnt + c_tick_one;
            if (w_sample) begin
              r_par   <= rxs;
              r_state <= STOP;
            end
          end

          STOP: begin
            r_tick_cnt <= w_sample ? '0 : r_tick_cnt + c_tick_one;
            if (w_sample) begin
              r_valid     <= 1'b1;
              r_data      <= r_shift & w_mask;
              r_perr      <= w_perr;
              r_ferr      <= !rxs;
              r_brk       <= w_brk;
              r_need_high <= !rxs;  // break implies stop sampled low
              r_state     <= IDLE;
              r_busy      <= 1'b0;
            end
          end

          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_valid    = r_valid;
  assign rx_data     = r_data;
  assign parity_err  = r_perr;
  assign framing_err = r_ferr;
  assign break_det   = r_brk;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_framer
// Purpose : Directed self-checking bench for uart_rx_framer.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx_framer;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] lcr;
  logic       rxd;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       framing_err;
  logic       break_det;
  logic       busy;

  int n_checks;
  int n_errors;
  int n_valid;
  int v0;
  int tick_div;
  logic prev_valid;
  logic wide_pulse;

  uart_rx_framer #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .lcr         (lcr),
    .rxd         (rxd),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .break_det   (break_det),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick changes on the falling edge so it is stable at rising edges
  initial begin
    tick_div  = 0;
    baud_tick = 1'b0;
  end
  always @(negedge clk) begin
    tick_div  = (tick_div + 1) % TICK_DIV;
    baud_tick = (tick_div == 0);
  end

  // Count completed frames and catch any rx_valid wider than one cycle
  initial begin
    n_valid    = 0;
    prev_valid = 1'b0;
    wide_pulse = 1'b0;
  end
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid = n_valid + 1;
      if (prev_valid) wide_pulse = 1'b1;
    end
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the rising edge on which the DUT consumed a tick
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int nticks);
    rxd = b;
    wait_ticks(nticks);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input bit p, input bit stop);
    send_bit(1'b0, OVERSAMPLE);
    for (int i = 0; i < nb; i++) send_bit(d[i], OVERSAMPLE);
    if (pen) send_bit(p, OVERSAMPLE);
    send_bit(stop, OVERSAMPLE);
    send_bit(1'b1, 24);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    rxd      = 1'b1;
    lcr      = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_perr", {31'd0, parity_err}, 32'd0);
    check("reset_ferr", {31'd0, framing_err}, 32'd0);
    check("reset_brk", {31'd0, break_det}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);

    // 8N1, 0xA5
    lcr = 8'h03;
    v0  = n_valid;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("a5_count", n_valid - v0, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("a5_perr", {31'd0, parity_err}, 32'd0);
    check("a5_ferr", {31'd0, framing_err}, 32'd0);
    check("a5_brk", {31'd0, break_det}, 32'd0);
    check("a5_busy", {31'd0, busy}, 32'd0);

    // 7E1, 0x55 has four ones: parity bit 0 is correct, 1 is wrong
    lcr = 8'h1A;
    v0  = n_valid;
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1);
    check("7e1_good_count", n_valid - v0, 32'd1);
    check("7e1_good_data", {24'd0, rx_data}, 32'h0000_0055);
    check("7e1_good_perr", {31'd0, parity_err}, 32'd0);
    v0 = n_valid;
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
    check("7e1_bad_count", n_valid - v0, 32'd1);
    check("7e1_bad_data", {24'd0, rx_data}, 32'h0000_0055);
    check("7e1_bad_perr", {31'd0, parity_err}, 32'd1);
    check("7e1_bad_ferr", {31'd0, framing_err}, 32'd0);

    // 5-bit, stick parity expecting 1; send 0, and drive high "extra" bits
    // beyond the word into the idle period
    lcr = 8'h28;
    v0  = n_valid;
    send_frame(8'hFF, 5, 1'b1, 1'b0, 1'b1);
    check("stick_count", n_valid - v0, 32'd1);
    check("stick_data", {24'd0, rx_data}, 32'h0000_001F);
    check("stick_perr", {31'd0, parity_err}, 32'd1);
    check("stick_ferr", {31'd0, framing_err}, 32'd0);

    // Framing error on 0x3C, then a clean 0x81
    lcr = 8'h03;
    v0  = n_valid;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check("ferr_count", n_valid - v0, 32'd1);
    check("ferr_data", {24'd0, rx_data}, 32'h0000_003C);
    check("ferr_ferr", {31'd0, framing_err}, 32'd1);
    check("ferr_brk", {31'd0, break_det}, 32'd0);
    v0 = n_valid;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    check("after_ferr_count", n_valid - v0, 32'd1);
    check("after_ferr_data", {24'd0, rx_data}, 32'h0000_0081);
    check("after_ferr_ferr", {31'd0, framing_err}, 32'd0);
    check("after_ferr_perr", {31'd0, parity_err}, 32'd0);

    // Reset during DATA: outputs clear at once, no frame reported
    v0 = n_valid;
    send_bit(1'b0, OVERSAMPLE);
    send_bit(1'b1, 20);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_mid_data", {24'd0, rx_data}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ferr", {31'd0, framing_err}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(200);
    check("rst_mid_count", n_valid - v0, 32'd0);
    check("rst_mid_busy_after", {31'd0, busy}, 32'd0);

    // Break: low for three frame times, exactly one frame reported
    lcr = 8'h03;
    v0  = n_valid;
    send_bit(1'b0, 3 * 10 * OVERSAMPLE);
    check("brk_count_low", n_valid - v0, 32'd1);
    check("brk_busy_low", {31'd0, busy}, 32'd0);
    send_bit(1'b1, 2 * OVERSAMPLE);
    check("brk_count", n_valid - v0, 32'd1);
    check("brk_data", {24'd0, rx_data}, 32'd0);
    check("brk_brk", {31'd0, break_det}, 32'd1);
    check("brk_ferr", {31'd0, framing_err}, 32'd1);
    check("brk_perr", {31'd0, parity_err}, 32'd0);

    // Receiver recovers after break
    v0 = n_valid;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check("post_brk_count", n_valid - v0, 32'd1);
    check("post_brk_data", {24'd0, rx_data}, 32'h0000_005A);
    check("post_brk_brk", {31'd0, break_det}, 32'd0);

    // 5-tick glitch is a false start
    v0 = n_valid;
    send_bit(1'b0, 5);
    send_bit(1'b1, 2 * OVERSAMPLE);
    check("glitch_count", n_valid - v0, 32'd0);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    check("valid_width", {31'd0, wide_pulse}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case something above stalls
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- 16550A-compatible receive deframer.
- Oversamples the serial input `rxd` at 16x using a baud enable, and reassembles 5-8 data bits LSB-first.
- Checks parity (none/odd/even/stick) and the stop bit, and detects break.
- Consumes the framing fields of the Line Control Register (word length, stop bits, parity control) and feeds the RX FIFO and the Line Status Register error bits.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit time; must be even and ≥4.
- SYNC_STAGES, 2, number of metastability flops on `rxd`.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk enable, OVERSAMPLE per bit time
- lcr  input  8  Line Control Register value; bits [5:0] used, [7:6] ignored
- rxd  input  1  serial input, idle high
- rx_valid  output  1  one-clk pulse: a frame has completed
- rx_data  output  8  received character, zero-extended above the word length
- parity_err  output  1  valid with rx_valid
- framing_err  output  1  valid with rx_valid; stop bit sampled 0
- break_det  output  1  valid with rx_valid; data, parity and stop all 0
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset state:
  - all outputs 0;
  - synchronizer flops reset to 1;
  - FSM in IDLE;
  - counters 0.
- `rxd` passes through the SYNC_STAGES synchronizer. All logic uses the synchronized value `rxs`. All counting advances only on `baud_tick`.
- IDLE:
  - on `baud_tick` with `rxs`=0, go to START with tick counter cleared;
  - latch `lcr[5:0]` into a shadow register;
  - later `lcr` changes are ignored until the next frame.
- START:
  - at tick OVERSAMPLE/2-1 (mid-bit), sample `rxs`;
  - if 1, it is a false start: return to IDLE, no `rx_valid`;
  - if 0, go to DATA with tick counter and bit counter cleared.
- DATA:
  - sample every OVERSAMPLE ticks (mid-bit) and shift in LSB-first;
  - bit count is 5 + shadow[1:0];
  - after the last bit, go to PARITY if shadow[3]=1, else go to STOP.
- PARITY:
  - sample the parity bit `p`; `d` is the received data bits only;
  - expected value by shadow[5:4]:
    - 00 odd: `^d ^ p` must be 1;
    - 01 even: `^d ^ p` must be 0;
    - 10 stick: `p` must be 1;
    - 11 stick: `p` must be 0.
- STOP:
  - sample the first stop bit only; shadow[2] (1.5/2 stop bits) is not checked by the receiver, per 16550A;
  - `framing_err` = (sample==0).
- Frame completion:
  - on the stop-sample tick, register the results;
  - the next clk pulses `rx_valid` for exactly 1 cycle, with `rx_data`, `parity_err`, `framing_err` and `break_det` stable from that cycle until the next `rx_valid`;
  - `parity_err` = 0 when parity is disabled;
  - `break_det` = all sampled data, parity (if enabled) and stop bits are 0.
- After STOP, go to IDLE. If `framing_err` or `break_det`, stay in IDLE until `rxs` has been seen high on a tick; this prevents a held-low break from being received as back-to-back frames.
- Latency: `rx_valid` asserts 1 clk after the mid-point of the stop bit, i.e. (1 + N + P)·OVERSAMPLE + OVERSAMPLE/2 ticks after the start edge, plus synchronizer delay.
- Counters:
  - the tick counter is log2(OVERSAMPLE) bits and wraps naturally;
  - the bit counter is 3 bits.
- `rx_data` bits at and above the word length are forced to 0.
- Reset asserted mid-frame aborts immediately to the reset state; no `rx_valid` is produced.
- A glitch shorter than OVERSAMPLE/2 ticks at the start is rejected as a false start.

Decomposition:
- Shared package `uart_pkg`:
  - LCR field positions (WLS, STB, PEN, EPS, SP);
  - word-length and parity-mode enums;
  - `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - function `wls_to_bits()`.
- One sub-module `uart_sync` (SYNC_STAGES flop chain, reset-to-1), reusable by the modem-status inputs.

Test Plan:
- lcr=8'h03 (8N1), send 8'hA5 with a good stop bit -> one `rx_valid`, `rx_data`=8'hA5, all error flags 0.
- lcr=8'h1A (7E1), send 7'h55 with parity bit 0 -> `parity_err`=0; resend with parity bit 1 -> `parity_err`=1, `rx_data`=8'h55.
- lcr=8'h28 (5-bit, stick parity, expected 1), send 5'h1F with parity bit 0 -> `parity_err`=1, `rx_data`=8'h1F, upper bits 0.
- lcr=8'h03, send 8'h3C with stop bit 0 then hold `rxd` high -> `framing_err`=1, `break_det`=0; the next good frame 8'h81 is received cleanly.
- Hold `rxd` low for 3 frame times, then release -> exactly one `rx_valid` with `rx_data`=0, `break_det`=1, `framing_err`=1; no further `rx_valid` until `rxd` returns high.
- Low pulse of 5 ticks on idle `rxd` -> no `rx_valid`, `busy` returns to 0. Separately, assert rst_n=0 during DATA -> all outputs 0, no frame reported.
